pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, the data path width in bits.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port FLUSH, input, 1, synchronous discard of all held data.
REQ-005 SHALL have port IN_VALID, input, 1, upstream has data on D.
REQ-006 SHALL have port IN_READY, output, 1, block can accept D this cycle.
REQ-007 SHALL have port D, input, NUM_BITS, upstream data.
REQ-008 SHALL have port OUT_VALID, output, 1, Q holds valid data.
REQ-009 SHALL have port OUT_READY, input, 1, downstream accepts Q this cycle.
REQ-010 SHALL have port Q, output, NUM_BITS, downstream data.

Function
REQ-011 SHALL hold two NUM_BITS registers: MAIN, which drives Q, and SKID, the overflow entry.
REQ-012 SHALL implement states EMPTY (no data), BUSY (MAIN valid, SKID free) and FULL (MAIN and SKID valid).
REQ-013 SHALL define an input transfer as IN_VALID and IN_READY high at a rising CLK edge.
REQ-014 SHALL define an output transfer as OUT_VALID and OUT_READY high at a rising CLK edge.
REQ-015 SHALL drive IN_READY from a register, high exactly when state is not FULL; no combinational path from OUT_READY.
REQ-016 SHALL drive OUT_VALID high exactly when state is BUSY or FULL.
REQ-017 SHALL follow these transitions from EMPTY:
- input transfer -> BUSY, MAIN <= D.
- otherwise stay in EMPTY.
REQ-018 SHALL follow these transitions from BUSY:
- input transfer, no output transfer -> FULL, SKID <= D.
- input and output transfer together -> stay in BUSY, MAIN <= D.
- output transfer only -> EMPTY.
- neither -> stay in BUSY.
REQ-019 SHALL follow these transitions from FULL:
- output transfer -> BUSY, MAIN <= SKID.
- otherwise stay in FULL.
- no input transfer is possible in FULL.
REQ-020 SHALL give latency of one cycle: data accepted at edge N appears on Q with OUT_VALID high after edge N, provided MAIN was free or being drained.
REQ-021 SHALL sustain one transfer per cycle when OUT_READY stays high; SKID is never used in that case.
REQ-022 SHALL deliver data in acceptance order with no loss or duplication.
REQ-023 SHALL keep Q and OUT_VALID stable while OUT_VALID is high and OUT_READY is low.
REQ-024 SHALL let Q keep its last MAIN value in EMPTY; Q is don't-care to consumers when OUT_VALID is low.
REQ-025 SHALL, on FLUSH high at an edge, go to EMPTY and drop MAIN and SKID contents, including any same-edge input transfer.
REQ-026 SHALL have IN_READY high on the cycle after a flush.
REQ-027 SHALL ignore D while IN_VALID is low.

Reset
REQ-028 SHALL, on RST high at an edge, set state EMPTY, MAIN = 0, SKID = 0, Q = 0, OUT_VALID = 0, IN_READY = 1.
REQ-029 SHALL give RST priority over FLUSH and over all transfers.
REQ-030 SHALL treat reset asserted mid-operation, including in FULL, exactly like reset from idle; no held data survives.

Verification (NUM_BITS = 4)
REQ-031 Reset:
- stimulus: RST high one edge, then low.
- required: Q = 0000, OUT_VALID = 0, IN_READY = 1.
REQ-032 Streaming:
- stimulus: OUT_READY = 1; D = 0001, 0010, 0011, 0100 with IN_VALID high on consecutive edges.
- required: Q shows the same values one cycle later, one per cycle, with IN_READY high throughout.
REQ-033 Backpressure:
- stimulus: OUT_READY = 0; send 0101 then 0110.
- required: state is FULL, IN_READY = 0, Q holds 0101; 0111 offered meanwhile is not accepted.
- then raise OUT_READY: Q gives 0101, then 0110, then 0111 on successive cycles.
REQ-034 Simultaneous transfer:
- stimulus: in BUSY holding 1000, OUT_READY = 1, IN_VALID = 1, D = 1001.
- required: next Q = 1001, state stays BUSY.
REQ-035 Flush:
- stimulus: in FULL, FLUSH high one edge while IN_VALID = 1.
- required: OUT_VALID = 0, IN_READY = 1, no flushed value ever appears with OUT_VALID high.
REQ-036 Reset priority:
- stimulus: RST and FLUSH high together while in FULL with both transfers requested.
- required: full reset state per REQ-028.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between valid/ready stages.
// IN_READY is registered so OUT_READY never reaches upstream combinationally.
module pipe_skid_reg #(
  parameter int NUM_BITS = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FLUSH,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [NUM_BITS-1:0] D,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [NUM_BITS-1:0] Q
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] main_q, main_d;
  logic [NUM_BITS-1:0] skid_q, skid_d;
  logic                in_ready_q, in_ready_d;
  logic                in_xfer;
  logic                out_xfer;

  assign in_xfer  = IN_VALID & in_ready_q;
  assign out_xfer = OUT_READY & (state_q != EMPTY);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_d  = D;
        end
      end
      BUSY: begin
        if (in_xfer && !out_xfer) begin
          state_d = FULL;
          skid_d  = D;
        end else if (in_xfer && out_xfer) begin
          main_d = D;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush discards everything, including a same-edge input transfer.
    if (FLUSH) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = (state_q != EMPTY);
  assign Q         = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: FIFO-of-two queue model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_pipe_skid_reg;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       FLUSH = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [3:0] D = 4'd0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [3:0] Q;

  int checks = 0;
  int errors = 0;

  logic [3:0] mq[$];

  pipe_skid_reg #(.NUM_BITS(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .FLUSH(FLUSH),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .D(D),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .Q(Q)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drv(input logic rst, input logic fl, input logic iv,
                     input logic [3:0] d, input logic ordy);
    RST = rst;
    FLUSH = fl;
    IN_VALID = iv;
    D = d;
    OUT_READY = ordy;
  endtask

  // One clock edge: advance the queue model, then compare the DUT to it.
  task automatic step();
    bit ix, ox;
    ix = IN_VALID && (mq.size() < 2);
    ox = OUT_READY && (mq.size() > 0);
    @(posedge CLK);
    if (RST || FLUSH) begin
      mq.delete();
    end else begin
      if (ox) void'(mq.pop_front());
      if (ix) mq.push_back(D);
    end
    #1;
    if (^{OUT_VALID, IN_READY} === 1'bx) begin
      checks++;
      errors++;
      $display("FAIL xstate: out_valid %b in_ready %b", OUT_VALID, IN_READY);
    end else begin
      chk("model_out_valid", int'(OUT_VALID), int'(mq.size() > 0));
      chk("model_in_ready", int'(IN_READY), int'(mq.size() < 2));
      if (mq.size() > 0)
        chk("model_q", int'(Q), int'(mq[0]));
    end
  endtask

  initial begin
    // Reset
    drv(1, 0, 0, 4'd0, 0);
    step();
    drv(0, 0, 0, 4'd0, 0);
    chk("reset_q", int'(Q), 0);
    chk("reset_ov", int'(OUT_VALID), 0);
    chk("reset_ir", int'(IN_READY), 1);

    // Streaming 1..4 with OUT_READY high
    for (int i = 1; i <= 4; i++) begin
      drv(0, 0, 1, 4'(i), 1);
      step();
      chk("stream_q", int'(Q), i);
      chk("stream_ov", int'(OUT_VALID), 1);
      chk("stream_ir", int'(IN_READY), 1);
    end
    drv(0, 0, 0, 4'd0, 1);
    step();
    chk("stream_drain_ov", int'(OUT_VALID), 0);

    // Backpressure: 5, 6 fill, 7 refused while full
    drv(0, 0, 1, 4'd5, 0);
    step();
    drv(0, 0, 1, 4'd6, 0);
    step();
    chk("bp_full_ir", int'(IN_READY), 0);
    chk("bp_full_q", int'(Q), 5);
    drv(0, 0, 1, 4'd7, 0);
    step();
    chk("bp_refuse_ir", int'(IN_READY), 0);
    chk("bp_refuse_q", int'(Q), 5);
    drv(0, 0, 1, 4'd7, 1);
    step();
    chk("bp_drain_q6", int'(Q), 6);
    step();
    chk("bp_drain_q7", int'(Q), 7);
    chk("bp_drain_ov7", int'(OUT_VALID), 1);
    drv(0, 0, 0, 4'd0, 1);
    step();
    chk("bp_empty_ov", int'(OUT_VALID), 0);

    // Simultaneous transfer in BUSY
    drv(0, 0, 1, 4'd8, 0);
    step();
    chk("sim_q8", int'(Q), 8);
    drv(0, 0, 1, 4'd9, 1);
    step();
    chk("sim_q9", int'(Q), 9);
    chk("sim_busy_ir", int'(IN_READY), 1);
    chk("sim_busy_ov", int'(OUT_VALID), 1);
    drv(0, 0, 0, 4'd0, 1);
    step();

    // Flush in FULL with a same-edge input
    drv(0, 0, 1, 4'hA, 0);
    step();
    drv(0, 0, 1, 4'hB, 0);
    step();
    chk("fl_full_ir", int'(IN_READY), 0);
    drv(0, 1, 1, 4'hC, 0);
    step();
    chk("fl_ov", int'(OUT_VALID), 0);
    chk("fl_ir", int'(IN_READY), 1);
    drv(0, 0, 0, 4'd0, 1);
    step();
    chk("fl_after_ov", int'(OUT_VALID), 0);
    step();

    // Reset beats flush and transfers while FULL
    drv(0, 0, 1, 4'd1, 0);
    step();
    drv(0, 0, 1, 4'd2, 0);
    step();
    drv(1, 1, 1, 4'd3, 1);
    step();
    chk("rp_q", int'(Q), 0);
    chk("rp_ov", int'(OUT_VALID), 0);
    chk("rp_ir", int'(IN_READY), 1);
    drv(0, 0, 0, 4'd0, 1);
    step();
    chk("rp_after_ov", int'(OUT_VALID), 0);

    // Mid-stream mix: D ignored while IN_VALID low, alternating stalls
    for (int i = 0; i < 12; i++) begin
      drv(0, 0, i[0], 4'(i + 3), i[1] | i[2]);
      step();
    end
    drv(0, 0, 0, 4'd0, 1);
    step();
    step();
    step();
    chk("mix_end_ov", int'(OUT_VALID), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
